// File: rtl/stft_frame_scheduler_pkg.sv
// stft_pkg: shared FSM state type and default geometry for the STFT scheduler
// and the overlap-add generator that consumes its frame_done pulses.
package stft_pkg;
    localparam int DEF_FRAME_LEN = 4096;
    localparam int DEF_HOP_LEN   = 1024;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_BUF_AW    = 14;
    localparam int SAMPLE_W      = 16;
    localparam int IFFT_W        = 16;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_IFFT} state_t;
endpackage

// File: rtl/stft_frame_scheduler_hop_trigger_gen.sv
// hop_trigger_gen: tracks ring buffer fill and hop phase, firing a frame trigger
// with the base address of the newest FRAME_LEN samples.
module hop_trigger_gen import stft_pkg::*; #(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP_LEN   = DEF_HOP_LEN,
    parameter int BUF_AW    = DEF_BUF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sample_valid,
    output logic [BUF_AW-1:0] o_wr_ptr,
    output logic              o_trig,
    output logic [BUF_AW-1:0] o_base
);
    localparam int HC_W = HOP_LEN > 1 ? $clog2(HOP_LEN) : 1;
    localparam int FC_W = $clog2(FRAME_LEN) + 1;

    logic [BUF_AW-1:0] r_wr_ptr;
    logic [HC_W-1:0]   r_hop_cnt;
    logic [FC_W-1:0]   r_fill_cnt;
    logic              w_hop_end;
    logic              w_full;

    assign w_hop_end = r_hop_cnt == HC_W'(HOP_LEN - 1);
    // The incoming sample completes the frame when FRAME_LEN-1 are already held.
    assign w_full    = r_fill_cnt >= FC_W'(FRAME_LEN - 1);
    assign o_trig    = i_sample_valid && w_hop_end && w_full;
    assign o_base    = r_wr_ptr + BUF_AW'(1) - BUF_AW'(FRAME_LEN);
    assign o_wr_ptr  = r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_hop_cnt  <= '0;
            r_fill_cnt <= '0;
        end else if (i_sample_valid) begin
            r_wr_ptr   <= r_wr_ptr + BUF_AW'(1);
            r_hop_cnt  <= w_hop_end ? '0 : r_hop_cnt + HC_W'(1);
            r_fill_cnt <= r_fill_cnt == FC_W'(FRAME_LEN) ? r_fill_cnt : r_fill_cnt + FC_W'(1);
        end
    end
endmodule

// File: rtl/stft_frame_scheduler.sv
// stft_frame_scheduler: fires FFT frame loads every hop, streams read addresses,
// then consumes the IFFT frame and pulses frame_done for overlap-add.
module stft_frame_scheduler import stft_pkg::*; #(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP_LEN   = DEF_HOP_LEN,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BUF_AW    = DEF_BUF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sample_valid,
    output logic [BUF_AW-1:0] o_wr_ptr,
    output logic [BUF_AW-1:0] o_fft_load_addr,
    output logic              o_fft_load_valid,
    output logic              o_fft_load_last,
    input  logic              i_fft_load_ready,
    input  logic              i_ifft_valid,
    input  logic [ADDR_W-1:0] i_ifft_user,
    output logic              o_ifft_ready,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_seq_err,
    input  logic              i_clr_status
);
    state_t            r_state, w_next;
    logic [BUF_AW-1:0] r_base, r_pend_base, w_trig_base;
    logic [ADDR_W-1:0] r_beat, r_exp_idx;
    logic              r_pend, r_done, r_overrun, r_seq_err;
    logic              w_trig, w_start, w_load_hs, w_ifft_hs, w_load_end, w_ifft_end;
    logic              w_repend, w_drop, w_mis;

    hop_trigger_gen #(
        .FRAME_LEN(FRAME_LEN),
        .HOP_LEN  (HOP_LEN),
        .BUF_AW   (BUF_AW)
    ) u_hop (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sample_valid(i_sample_valid),
        .o_wr_ptr      (o_wr_ptr),
        .o_trig        (w_trig),
        .o_base        (w_trig_base)
    );

    assign w_start    = r_state == IDLE && (w_trig || r_pend);
    assign w_load_hs  = r_state == LOAD && i_fft_load_ready;
    assign w_ifft_hs  = r_state == WAIT_IFFT && i_ifft_valid;
    assign w_load_end = w_load_hs && r_beat == ADDR_W'(FRAME_LEN - 1);
    assign w_ifft_end = w_ifft_hs && r_exp_idx == ADDR_W'(FRAME_LEN - 1);
    assign w_mis      = w_ifft_hs && i_ifft_user != r_exp_idx;
    // In IDLE a pending frame is served first and a coincident trigger takes its slot.
    assign w_repend   = w_trig && (r_state == IDLE ? r_pend : !r_pend);
    assign w_drop     = w_trig && r_state != IDLE && r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        o_fft_load_valid = 1'b0;
        o_ifft_ready     = 1'b0;
        case (r_state)
            IDLE:      w_next = w_start ? LOAD : IDLE;
            LOAD: begin
                o_fft_load_valid = 1'b1;
                w_next           = w_load_end ? WAIT_IFFT : LOAD;
            end
            WAIT_IFFT: begin
                o_ifft_ready = 1'b1;
                w_next       = w_ifft_end ? IDLE : WAIT_IFFT;
            end
            default:   w_next = IDLE;
        endcase
        o_fft_load_addr = o_fft_load_valid ? r_base + BUF_AW'(r_beat) : '0;
        o_fft_load_last = o_fft_load_valid && r_beat == ADDR_W'(FRAME_LEN - 1);
        o_busy          = r_state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_pend_base <= '0;
            r_beat      <= '0;
            r_exp_idx   <= '0;
            r_pend      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            if (w_start) r_base <= r_pend ? r_pend_base : w_trig_base;
            if (w_repend) r_pend_base <= w_trig_base;
            if (w_load_hs) r_beat <= r_beat + ADDR_W'(1);
            if (w_ifft_hs) r_exp_idx <= r_exp_idx + ADDR_W'(1);
            r_pend    <= w_repend ? 1'b1 : (r_state == IDLE ? 1'b0 : r_pend);
            r_done    <= w_ifft_end;
            r_overrun <= w_drop || (r_overrun && !i_clr_status);
            r_seq_err <= w_mis || (r_seq_err && !i_clr_status);
        end
    end

    assign o_frame_done = r_done;
    assign o_overrun    = r_overrun;
    assign o_seq_err    = r_seq_err;
endmodule

// File: doc/stft_frame_scheduler.md
Name: stft_frame_scheduler

Overview:
Sequences the STFT/ISTFT pipeline around the overlap-add stage. It counts incoming audio samples into the input ring buffer and fires one FFT frame load every HOP_LEN samples. It streams the frame's read addresses to the FFT loader, then accepts the returning IFFT frame (data indexed by its user field). It pulses frame_done to the overlap-add generator after the last beat and flags overruns and out-of-order IFFT beats.

Parameters:
FRAME_LEN, 4096, samples per FFT/IFFT frame (power of two)
HOP_LEN, 1024, samples between frame starts (power of two, <= FRAME_LEN)
ADDR_W, 12, IFFT user/index width, log2(FRAME_LEN)
BUF_AW, 14, ring buffer address width; 2**BUF_AW >= 2*FRAME_LEN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sample_valid  in  1  one audio sample written to ring buffer at wr_ptr this cycle
wr_ptr  out  BUF_AW  ring buffer write address
fft_load_addr  out  BUF_AW  ring buffer read address for current FFT beat
fft_load_valid  out  1  load beat valid
fft_load_last  out  1  final beat of frame
fft_load_ready  in  1  FFT loader accepts beat
ifft_valid  in  1  IFFT output beat valid
ifft_user  in  ADDR_W  IFFT output sample index
ifft_ready  out  1  scheduler accepts IFFT beat
frame_done  out  1  one-cycle pulse: full IFFT frame consumed
busy  out  1  state != IDLE
overrun  out  1  sticky: hop trigger lost
seq_err  out  1  sticky: ifft_user != expected index
clr_status  in  1  synchronous clear of overrun/seq_err

Behaviour:
- Reset (rst=0, async): wr_ptr=0, hop_cnt=0, fill_cnt=0, pending=0, state=IDLE. All outputs 0.
- sample_valid: wr_ptr+=1 (wraps mod 2**BUF_AW). hop_cnt+=1 (wraps at HOP_LEN). fill_cnt saturates at FRAME_LEN.
- Hop trigger: sample_valid when hop_cnt==HOP_LEN-1 and fill_cnt (incl. this sample) >= FRAME_LEN. On trigger, latch base = wr_ptr+1-FRAME_LEN (mod 2**BUF_AW), i.e. the oldest of the newest FRAME_LEN samples.
- Trigger outside IDLE: set pending with latched base. If pending is already set: overrun<=1, newest trigger dropped, older base kept.
- FSM:
  - IDLE: on trigger or pending, go to LOAD and clear pending. Trigger and pending in the same cycle: serve pending, re-pend the new trigger.
  - LOAD: fft_load_valid=1, fft_load_addr=base+beat. Advance beat only on valid&ready. fft_load_last=1 when beat==FRAME_LEN-1. On last handshake go to WAIT_IFFT. Address and valid are held stable while ready=0.
  - WAIT_IFFT: ifft_ready=1. On each valid&ready, compare ifft_user to exp_idx. A mismatch sets seq_err, but counting continues on exp_idx. On handshake with exp_idx==FRAME_LEN-1, pulse frame_done next cycle and go to IDLE.
- IFFT beats arriving outside WAIT_IFFT are not accepted (ifft_ready=0).
- Latency: trigger in IDLE gives fft_load_valid on the following cycle. frame_done is registered, one cycle after the last IFFT handshake.
- clr_status clears the sticky flags. A same-cycle set wins over clear.
- Reset mid-frame aborts everything; no frame_done is emitted.
- Counters are unsigned, and all wraps are natural modulo width.

Decomposition:
- Package stft_pkg: FSM state enum (IDLE, LOAD, WAIT_IFFT); default FRAME_LEN/HOP_LEN/widths as localparams; the sample/IFFT data width constants shared with the overlap-add generator.
- One sub-module: hop_trigger_gen. It holds wr_ptr, hop_cnt and fill_cnt, and emits trigger plus base.

Test Plan (FRAME_LEN=16, HOP_LEN=4, BUF_AW=6, ADDR_W=4):
- Priming: 15 sample_valid pulses give no trigger. The 16th gives a trigger; load addresses run 0..15, last asserted on addr 15, wr_ptr=16.
- Hop cadence: after the priming frame's IFFT returns, the 20th sample triggers with base=4. The 24th triggers with base=8.
- Backpressure: fft_load_ready toggled 1,0,0,1 gives addr held across stalls and exactly 16 handshakes.
- IFFT return: 16 beats ifft_user 0..15 give frame_done 1 cycle after beat 15 and state IDLE. Beats with user 0..4,6,5,7..15 give seq_err=1 and frame_done still pulses.
- Overrun: hold ifft_valid=0 while 8 more samples arrive. The first trigger is pending, the second sets overrun=1. After the frame completes, the next load uses base of the first pending trigger. clr_status then gives overrun=0.
- Async reset: assert rst=0 mid-LOAD (beat 7) and all outputs go to 0 immediately. After release, 16 samples are needed before a new trigger.
